// File: rtl/pipelined_adder_if.sv
// Operand/result handshake bundle for pipelined_adder.
// The master drives operands and out_ready; the slave (the adder) returns results and in_ready.
interface pipelined_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             carry_in;
  logic             op_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             overflow;

  modport master (
    output in_valid, x, y, carry_in, op_sub, out_ready,
    input  in_ready, out_valid, sum, carry_out, overflow
  );

  modport slave (
    input  in_valid, x, y, carry_in, op_sub, out_ready,
    output in_ready, out_valid, sum, carry_out, overflow
  );
endinterface

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract: WIDTH bits split into STAGES carry-chained chunks, one chunk per stage,
// with per-stage valid bits and collapsing bubbles under valid/ready flow control.
module pipelined_adder #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input logic              clk,
  input logic              rst_n,
  pipelined_adder_if.slave bus
);
  localparam int unsigned CW = WIDTH / STAGES;

  if (WIDTH < 1 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_param_check
    $error("pipelined_adder: WIDTH must be a non-zero multiple of STAGES");
  end

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];
  logic              ovf_q;

  logic [STAGES-1:0] ready;
  logic [STAGES-1:0] v_src;
  logic [STAGES-1:0] c_src;
  logic [STAGES-1:0] c_nxt;
  logic [WIDTH-1:0]  a_src [STAGES];
  logic [WIDTH-1:0]  b_src [STAGES];
  logic [WIDTH-1:0]  s_src [STAGES];
  logic [WIDTH-1:0]  s_nxt [STAGES];
  logic [CW:0]       chunk [STAGES];
  logic              ovf_nxt;

  // Stage k may load unless it and every stage after it are full with the output stalled.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      ready[k] = bus.out_ready | ((v_q >> k) != ({STAGES{1'b1}} >> k));
    end
  end

  always_comb begin
    a_src[0] = bus.x;
    b_src[0] = bus.op_sub ? ~bus.y : bus.y;
    s_src[0] = '0;
    c_src[0] = bus.carry_in;
    v_src[0] = bus.in_valid;
    for (int k = 1; k < STAGES; k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      s_src[k] = s_q[k-1];
      c_src[k] = c_q[k-1];
      v_src[k] = v_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      chunk[k] = {1'b0, a_src[k][k*CW +: CW]} + {1'b0, b_src[k][k*CW +: CW]}
               + {{CW{1'b0}}, c_src[k]};
      s_nxt[k] = s_src[k];
      s_nxt[k][k*CW +: CW] = chunk[k][CW-1:0];
      c_nxt[k] = chunk[k][CW];
    end
    // Carry into the MSB is recovered as sum ^ a ^ b at that bit.
    ovf_nxt = c_nxt[STAGES-1] ^ s_nxt[STAGES-1][WIDTH-1]
            ^ a_src[STAGES-1][WIDTH-1] ^ b_src[STAGES-1][WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ready[k]) begin
          v_q[k] <= v_src[k];
        end
        // Data only moves with a valid beat so outputs keep the last result across bubbles.
        if (ready[k] && v_src[k]) begin
          a_q[k] <= a_src[k];
          b_q[k] <= b_src[k];
          s_q[k] <= s_nxt[k];
          c_q[k] <= c_nxt[k];
        end
      end
      if (ready[STAGES-1] && v_src[STAGES-1]) begin
        ovf_q <= ovf_nxt;
      end
    end
  end

  assign bus.in_ready  = ready[0];
  assign bus.out_valid = v_q[STAGES-1];
  assign bus.sum       = s_q[STAGES-1];
  assign bus.carry_out = c_q[STAGES-1];
  assign bus.overflow  = ovf_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder: main 8/2 instance plus 32/4 and 8/1 instances
// exercised in the throughput scenario.
module tb_pipelined_adder;
  localparam int unsigned W_M = 8;
  localparam int unsigned S_M = 2;
  localparam int unsigned W_W = 32;
  localparam int unsigned S_W = 4;
  localparam int unsigned W_N = 8;
  localparam int unsigned S_N = 1;

  localparam logic [7:0] DX  [5] = '{8'h0F, 8'hFF, 8'h7F, 8'h05, 8'h80};
  localparam logic [7:0] DY  [5] = '{8'h01, 8'h01, 8'h01, 8'h07, 8'h01};
  localparam logic       DCS [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam logic [7:0] DS  [5] = '{8'h10, 8'h00, 8'h80, 8'hFE, 8'h7F};
  localparam logic       DCO [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam logic       DOV [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  typedef struct packed {
    logic        cout;
    logic        ovf;
    logic [63:0] sum;
  } res_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipelined_adder_if #(.WIDTH(W_M)) bus_m ();
  pipelined_adder_if #(.WIDTH(W_W)) bus_w ();
  pipelined_adder_if #(.WIDTH(W_N)) bus_n ();

  pipelined_adder #(.WIDTH(W_M), .STAGES(S_M)) dut_m (.clk(clk), .rst_n(rst_n), .bus(bus_m));
  pipelined_adder #(.WIDTH(W_W), .STAGES(S_W)) dut_w (.clk(clk), .rst_n(rst_n), .bus(bus_w));
  pipelined_adder #(.WIDTH(W_N), .STAGES(S_N)) dut_n (.clk(clk), .rst_n(rst_n), .bus(bus_n));

  res_t exp_m[$];
  res_t exp_w[$];
  res_t exp_n[$];
  int   checks = 0;
  int   errors = 0;

  function automatic res_t model(input logic [63:0] a, input logic [63:0] b_raw,
                                 input logic cin, input logic sub, input int w);
    logic [63:0] mask;
    logic [63:0] b;
    logic [64:0] full;
    res_t        r;
    mask   = (64'd1 << w) - 64'd1;
    b      = (sub ? ~b_raw : b_raw) & mask;
    full   = {1'b0, a & mask} + {1'b0, b} + {64'd0, cin};
    r.sum  = full[63:0] & mask;
    r.cout = full[w];
    r.ovf  = (a[w-1] == b[w-1]) && (r.sum[w-1] != a[w-1]);
    return r;
  endfunction

  task automatic test_reset();
    logic [11:0] got;
    @(negedge clk);
    got = {bus_m.out_valid, bus_m.in_ready, bus_m.carry_out, bus_m.overflow, bus_m.sum};
    checks++;
    if (got !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_held: got %h expected %h", got, {4'b0100, 8'h00});
    end
    checks++;
    if ({bus_w.out_valid, bus_w.sum, bus_n.out_valid, bus_n.sum} !== 42'd0) begin
      errors++;
      $display("FAIL reset_other: got w=%b/%h n=%b/%h expected all zero",
               bus_w.out_valid, bus_w.sum, bus_n.out_valid, bus_n.sum);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    got = {bus_m.out_valid, bus_m.in_ready, bus_m.carry_out, bus_m.overflow, bus_m.sum};
    checks++;
    if (got !== {1'b0, 1'b1, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", got, {4'b0100, 8'h00});
    end
  endtask

  task automatic test_directed();
    res_t got;
    res_t exp;
    int   lat;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      bus_m.x        = DX[i];
      bus_m.y        = DY[i];
      bus_m.carry_in = DCS[i];
      bus_m.op_sub   = DCS[i];
      bus_m.in_valid = 1'b1;
      exp_m.push_back({DCO[i], DOV[i], 56'd0, DS[i]});
      @(posedge clk);
      #1 bus_m.in_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!bus_m.out_valid && lat < 10) begin
        @(negedge clk);
        lat++;
      end
      checks++;
      if (lat != int'(S_M)) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d cycles expected %0d", i, lat, S_M);
      end
      got = {bus_m.carry_out, bus_m.overflow, 56'd0, bus_m.sum};
      exp = exp_m.pop_front();
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL directed_result[%0d]: got %h expected %h", i, got, exp);
      end
    end
  endtask

  task automatic test_backpressure();
    int         sent = 0;
    int         recv = 0;
    int         stalls = 0;
    int         cyc = 0;
    logic       take;
    logic [7:0] vx;
    logic [7:0] vy;
    res_t       got;
    res_t       held;
    res_t       exp;
    @(posedge clk);
    #1;
    while (recv < 4 && cyc < 40) begin
      vx = 8'(8'h21 * (sent + 1));
      vy = 8'(8'h47 + sent * 3);
      bus_m.in_valid  = (sent < 4);
      bus_m.x         = vx;
      bus_m.y         = vy;
      bus_m.carry_in  = sent[0];
      bus_m.op_sub    = sent[1];
      bus_m.out_ready = (stalls >= 3);
      @(negedge clk);
      take = bus_m.in_valid && bus_m.in_ready;
      if (take) exp_m.push_back(model(64'(vx), 64'(vy), sent[0], sent[1], W_M));
      if (bus_m.out_valid && !bus_m.out_ready) begin
        got = {bus_m.carry_out, bus_m.overflow, 56'd0, bus_m.sum};
        if (stalls > 0) begin
          checks++;
          if (got !== held) begin
            errors++;
            $display("FAIL bp_stable: got %h expected %h", got, held);
          end
        end
        held = got;
        stalls++;
        checks++;
        if (bus_m.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp_in_ready: got %b expected 0", bus_m.in_ready);
        end
      end
      if (bus_m.out_valid && bus_m.out_ready) begin
        got = {bus_m.carry_out, bus_m.overflow, 56'd0, bus_m.sum};
        checks++;
        if (exp_m.size() == 0) begin
          errors++;
          $display("FAIL bp_extra: got %h expected no result", got);
        end else begin
          exp = exp_m.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL bp_result[%0d]: got %h expected %h", recv, got, exp);
          end
        end
        recv++;
      end
      @(posedge clk);
      #1;
      if (take) sent++;
      cyc++;
    end
    bus_m.in_valid  = 1'b0;
    bus_m.out_ready = 1'b1;
    checks++;
    if (recv != 4 || exp_m.size() != 0 || stalls != 3) begin
      errors++;
      $display("FAIL bp_count: got recv=%0d left=%0d stalls=%0d expected 4/0/3",
               recv, exp_m.size(), stalls);
    end
  endtask

  task automatic test_throughput();
    int   sm = 0, sw = 0, sn = 0;
    int   rm = 0, rw = 0, rn = 0;
    int   lm = -1, lw = -1, ln = -1;
    logic tm, tw, tn;
    res_t got;
    res_t exp;
    for (int cyc = 0; cyc < 300 && (rm < 100 || rw < 100 || rn < 100); cyc++) begin
      bus_m.in_valid = (sm < 100);
      bus_m.x        = 8'($urandom);
      bus_m.y        = 8'($urandom);
      bus_m.carry_in = 1'($urandom);
      bus_m.op_sub   = 1'($urandom);
      bus_w.in_valid = (sw < 100);
      bus_w.x        = 32'($urandom);
      bus_w.y        = 32'($urandom);
      bus_w.carry_in = 1'($urandom);
      bus_w.op_sub   = 1'($urandom);
      bus_n.in_valid = (sn < 100);
      bus_n.x        = 8'($urandom);
      bus_n.y        = 8'($urandom);
      bus_n.carry_in = 1'($urandom);
      bus_n.op_sub   = 1'($urandom);
      @(negedge clk);
      tm = bus_m.in_valid && bus_m.in_ready;
      tw = bus_w.in_valid && bus_w.in_ready;
      tn = bus_n.in_valid && bus_n.in_ready;
      if (tm) exp_m.push_back(model(64'(bus_m.x), 64'(bus_m.y), bus_m.carry_in, bus_m.op_sub, W_M));
      if (tw) exp_w.push_back(model(64'(bus_w.x), 64'(bus_w.y), bus_w.carry_in, bus_w.op_sub, W_W));
      if (tn) exp_n.push_back(model(64'(bus_n.x), 64'(bus_n.y), bus_n.carry_in, bus_n.op_sub, W_N));
      if (bus_m.out_valid) begin
        got = {bus_m.carry_out, bus_m.overflow, 56'd0, bus_m.sum};
        exp = (exp_m.size() != 0) ? exp_m.pop_front() : '1;
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL tp_m[%0d]: got %h expected %h", rm, got, exp);
        end
        rm++;
        lm = cyc;
      end
      if (bus_w.out_valid) begin
        got = {bus_w.carry_out, bus_w.overflow, 32'd0, bus_w.sum};
        exp = (exp_w.size() != 0) ? exp_w.pop_front() : '1;
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL tp_w[%0d]: got %h expected %h", rw, got, exp);
        end
        rw++;
        lw = cyc;
      end
      if (bus_n.out_valid) begin
        got = {bus_n.carry_out, bus_n.overflow, 56'd0, bus_n.sum};
        exp = (exp_n.size() != 0) ? exp_n.pop_front() : '1;
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL tp_n[%0d]: got %h expected %h", rn, got, exp);
        end
        rn++;
        ln = cyc;
      end
      @(posedge clk);
      #1;
      if (tm) sm++;
      if (tw) sw++;
      if (tn) sn++;
    end
    bus_m.in_valid = 1'b0;
    bus_w.in_valid = 1'b0;
    bus_n.in_valid = 1'b0;
    checks++;
    if (rm != 100 || lm != 99 + int'(S_M)) begin
      errors++;
      $display("FAIL tp_m_rate: got %0d results, last at %0d expected 100, %0d", rm, lm, 99 + S_M);
    end
    checks++;
    if (rw != 100 || lw != 99 + int'(S_W)) begin
      errors++;
      $display("FAIL tp_w_rate: got %0d results, last at %0d expected 100, %0d", rw, lw, 99 + S_W);
    end
    checks++;
    if (rn != 100 || ln != 99 + int'(S_N)) begin
      errors++;
      $display("FAIL tp_n_rate: got %0d results, last at %0d expected 100, %0d", rn, ln, 99 + S_N);
    end
  endtask

  task automatic test_reset_midflight();
    int   stale = 0;
    int   lat = 0;
    res_t got;
    res_t exp;
    bus_m.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus_m.in_valid = 1'b1;
      bus_m.x        = 8'(8'h3C + i);
      bus_m.y        = 8'h11;
      bus_m.carry_in = 1'b0;
      bus_m.op_sub   = 1'b0;
      @(posedge clk);
      #1;
    end
    bus_m.in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus_m.out_valid, bus_m.in_ready} !== 2'b10) begin
      errors++;
      $display("FAIL rst_prefill: got valid/ready %b%b expected 10", bus_m.out_valid, bus_m.in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus_m.out_valid, bus_m.in_ready, bus_m.carry_out, bus_m.overflow, bus_m.sum}
        !== {4'b0100, 8'h00}) begin
      errors++;
      $display("FAIL rst_mid: got v=%b r=%b c=%b o=%b s=%h expected v=0 r=1 c=0 o=0 s=00",
               bus_m.out_valid, bus_m.in_ready, bus_m.carry_out, bus_m.overflow, bus_m.sum);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus_m.out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (bus_m.out_valid) stale++;
    end
    checks++;
    if (stale != 0) begin
      errors++;
      $display("FAIL rst_stale: got %0d stale results expected 0", stale);
    end
    @(posedge clk);
    #1;
    bus_m.in_valid = 1'b1;
    bus_m.x        = 8'hC8;
    bus_m.y        = 8'h64;
    bus_m.carry_in = 1'b1;
    bus_m.op_sub   = 1'b1;
    exp_m.push_back(model(64'h0C8, 64'h064, 1'b1, 1'b1, W_M));
    @(posedge clk);
    #1 bus_m.in_valid = 1'b0;
    @(negedge clk);
    while (!bus_m.out_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    got = {bus_m.carry_out, bus_m.overflow, 56'd0, bus_m.sum};
    exp = exp_m.pop_front();
    checks++;
    if (!bus_m.out_valid || got !== exp) begin
      errors++;
      $display("FAIL rst_recover: got v=%b %h expected v=1 %h", bus_m.out_valid, got, exp);
    end
  endtask

  initial begin
    bus_m.in_valid = 1'b0; bus_m.x = '0; bus_m.y = '0;
    bus_m.carry_in = 1'b0; bus_m.op_sub = 1'b0; bus_m.out_ready = 1'b1;
    bus_w.in_valid = 1'b0; bus_w.x = '0; bus_w.y = '0;
    bus_w.carry_in = 1'b0; bus_w.op_sub = 1'b0; bus_w.out_ready = 1'b1;
    bus_n.in_valid = 1'b0; bus_n.x = '0; bus_n.y = '0;
    bus_n.carry_in = 1'b0; bus_n.op_sub = 1'b0; bus_n.out_ready = 1'b1;
    test_reset();
    test_directed();
    test_backpressure();
    test_throughput();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
